// File: rtl/pong_pkg.sv
// pong_pkg: shared types and default geometry for the two-player pong engine.
//   match_state_e : match state machine encoding (IDLE, SERVE, PLAY, GAME_OVER)
//   pos_t         : signed 13-bit screen coordinate, wide enough that
//                   candidate positions can go negative or past the screen edge
//   step()        : move a coordinate forward/backward by a 4-bit speed
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SERVE     = 2'd1,
    ST_PLAY      = 2'd2,
    ST_GAME_OVER = 2'd3
  } match_state_e;

  typedef logic signed [12:0] pos_t;

  localparam int DEF_GAME_WIDTH    = 1280;
  localparam int DEF_GAME_HEIGHT   = 720;
  localparam int DEF_PADDLE_WIDTH  = 16;
  localparam int DEF_PADDLE_HEIGHT = 128;
  localparam int DEF_PUCK_SIZE     = 32;
  localparam int DEF_WIN_SCORE     = 7;
  localparam int DEF_SERVE_FRAMES  = 60;

  // fwd=1 adds the speed (right/down), fwd=0 subtracts it (left/up).
  function automatic pos_t step(input pos_t p, input logic fwd, input logic [3:0] s);
    pos_t d;
    d = pos_t'({9'd0, s});
    return fwd ? (p + d) : (p - d);
  endfunction

endpackage

// File: rtl/block_sprite.sv
// block_sprite: solid rectangle sprite.
//   hcount_i, vcount_i : current pixel
//   x_i, y_i           : top-left corner of the rectangle (non-negative)
//   color_o            : COLOR when the pixel is inside, else 0
module block_sprite #(
  parameter int          WIDTH  = 128,
  parameter int          HEIGHT = 128,
  parameter logic [23:0] COLOR  = 24'hFF_FF_FF
) (
  input  logic [10:0] hcount_i,
  input  logic [9:0]  vcount_i,
  input  logic [12:0] x_i,
  input  logic [12:0] y_i,
  output logic [23:0] color_o
);

  localparam logic [13:0] W = 14'(WIDTH);
  localparam logic [13:0] H = 14'(HEIGHT);

  logic [13:0] h, v, x, y;
  logic        in_x, in_y;

  assign h = {3'd0, hcount_i};
  assign v = {4'd0, vcount_i};
  assign x = {1'b0, x_i};
  assign y = {1'b0, y_i};

  assign in_x    = (h >= x) && (h < x + W);
  assign in_y    = (v >= y) && (v < y + H);
  assign color_o = (in_x && in_y) ? COLOR : 24'h0;

endmodule

// File: rtl/pong_paddle_ctrl.sv
// pong_paddle_ctrl: combinational next-y for one paddle.
//   en_i     : paddle may move this frame
//   up_i     : move up (y decreases)
//   down_i   : move down (y increases)
//   speed_i  : pixels per frame
//   y_i      : current paddle y
//   y_o      : next paddle y, clamped to [0, GAME_HEIGHT-PADDLE_HEIGHT]
// Up and down together cancel out.
module pong_paddle_ctrl
  import pong_pkg::*;
#(
  parameter int GAME_HEIGHT   = DEF_GAME_HEIGHT,
  parameter int PADDLE_HEIGHT = DEF_PADDLE_HEIGHT
) (
  input  logic        en_i,
  input  logic        up_i,
  input  logic        down_i,
  input  logic [3:0]  speed_i,
  input  logic [12:0] y_i,
  output logic [12:0] y_o
);

  localparam pos_t Y_MAX = pos_t'(GAME_HEIGHT - PADDLE_HEIGHT);

  pos_t cand;

  always_comb begin
    cand = $signed(y_i);
    y_o  = y_i;
    if (en_i && (up_i ^ down_i)) begin
      cand = step($signed(y_i), down_i, speed_i);
      if (cand < 13'sd0) begin
        y_o = '0;
      end else if (cand > Y_MAX) begin
        y_o = Y_MAX;
      end else begin
        y_o = cand;
      end
    end
  end

endmodule

// File: rtl/pong_versus.sv
// pong_versus: two-player pong engine. Game state advances once per frame
// (nf_in strobe); sprites are rendered with one cycle of latency.
//   pixel_clk_in     : pixel clock
//   rst_in           : asynchronous active-high reset
//   control_in       : [3] right up, [2] right down, [1] left up, [0] left down
//   serve_in         : serve / restart request, latched until the next frame
//   puck_speed_in    : puck pixels per frame per axis
//   paddle_speed_in  : paddle pixels per frame
//   nf_in            : new-frame strobe
//   hcount_in        : pixel column
//   vcount_in        : pixel row
//   red/green/blue_out : registered pixel colour
//   score_l/r_out    : player scores
//   state_out        : match state (0 IDLE, 1 SERVE, 2 PLAY, 3 GAME_OVER)
// Build option: define PONG_AI_EN to have the right paddle track the puck
// instead of following control_in[3:2].
module pong_versus
  import pong_pkg::*;
#(
  parameter int GAME_WIDTH    = DEF_GAME_WIDTH,
  parameter int GAME_HEIGHT   = DEF_GAME_HEIGHT,
  parameter int PADDLE_WIDTH  = DEF_PADDLE_WIDTH,
  parameter int PADDLE_HEIGHT = DEF_PADDLE_HEIGHT,
  parameter int PUCK_SIZE     = DEF_PUCK_SIZE,
  parameter int WIN_SCORE     = DEF_WIN_SCORE,
  parameter int SERVE_FRAMES  = DEF_SERVE_FRAMES
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic [3:0]  control_in,
  input  logic        serve_in,
  input  logic [3:0]  puck_speed_in,
  input  logic [3:0]  paddle_speed_in,
  input  logic        nf_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic [3:0]  score_l_out,
  output logic [3:0]  score_r_out,
  output logic [1:0]  state_out
);

  localparam pos_t PUCK_X0    = pos_t'(GAME_WIDTH / 2 - PUCK_SIZE / 2);
  localparam pos_t PUCK_Y0    = pos_t'(GAME_HEIGHT / 2 - PUCK_SIZE / 2);
  localparam pos_t PAD_Y0     = pos_t'(GAME_HEIGHT / 2 - PADDLE_HEIGHT / 2);
  localparam pos_t PAD_R_X    = pos_t'(GAME_WIDTH - PADDLE_WIDTH);
  localparam pos_t HIT_L_X    = pos_t'(PADDLE_WIDTH);
  localparam pos_t HIT_R_X    = pos_t'(GAME_WIDTH - PADDLE_WIDTH - PUCK_SIZE);
  localparam pos_t PUCK_Y_MAX = pos_t'(GAME_HEIGHT - PUCK_SIZE);
  localparam pos_t G_HEIGHT   = pos_t'(GAME_HEIGHT);
  localparam pos_t P_SIZE     = pos_t'(PUCK_SIZE);
  localparam pos_t P_HEIGHT   = pos_t'(PADDLE_HEIGHT);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
  localparam logic [15:0] FRAME_LAST = 16'(SERVE_FRAMES - 1);

  match_state_e state_q, state_d;
  logic [3:0]   score_l_q, score_l_d, score_r_q, score_r_d;
  pos_t         puck_x_q, puck_x_d, puck_y_q, puck_y_d;
  logic         dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  pos_t         pad_l_q, pad_l_d, pad_r_q, pad_r_d;
  logic         serve_q, serve_d;
  logic [15:0]  frame_q, frame_d;
  logic [23:0]  rgb_q, rgb_d;

  // ---------------- paddles ----------------
  logic        pad_en, r_up, r_down;
  logic [12:0] pad_l_nx, pad_r_nx;

  assign pad_en = (state_q != ST_GAME_OVER);

`ifdef PONG_AI_EN
  pos_t puck_cy, pad_r_cy;
  assign puck_cy  = puck_y_q + pos_t'(PUCK_SIZE / 2);
  assign pad_r_cy = pad_r_q + pos_t'(PADDLE_HEIGHT / 2);
  assign r_up     = (puck_cy < pad_r_cy - pos_t'(PADDLE_HEIGHT / 4));
  assign r_down   = (puck_cy > pad_r_cy + pos_t'(PADDLE_HEIGHT / 4));
`else
  assign r_up   = control_in[3];
  assign r_down = control_in[2];
`endif

  pong_paddle_ctrl #(
    .GAME_HEIGHT  (GAME_HEIGHT),
    .PADDLE_HEIGHT(PADDLE_HEIGHT)
  ) u_pad_l (
    .en_i   (pad_en),
    .up_i   (control_in[1]),
    .down_i (control_in[0]),
    .speed_i(paddle_speed_in),
    .y_i    (pad_l_q),
    .y_o    (pad_l_nx)
  );

  pong_paddle_ctrl #(
    .GAME_HEIGHT  (GAME_HEIGHT),
    .PADDLE_HEIGHT(PADDLE_HEIGHT)
  ) u_pad_r (
    .en_i   (pad_en),
    .up_i   (r_up),
    .down_i (r_down),
    .speed_i(paddle_speed_in),
    .y_i    (pad_r_q),
    .y_o    (pad_r_nx)
  );

  // ---------------- puck motion and collisions ----------------
  pos_t nx, ny, nx_res, ny_res;
  logic dx_res, dy_res, miss_l, miss_r, overlap_l, overlap_r;

  // Overlap uses the paddle positions from before this frame's move.
  assign overlap_l = (puck_y_q + P_SIZE > pad_l_q) && (puck_y_q < pad_l_q + P_HEIGHT);
  assign overlap_r = (puck_y_q + P_SIZE > pad_r_q) && (puck_y_q < pad_r_q + P_HEIGHT);

  always_comb begin
    nx     = step(puck_x_q, dir_x_q, puck_speed_in);
    ny     = step(puck_y_q, dir_y_q, puck_speed_in);
    nx_res = nx;
    ny_res = ny;
    dx_res = dir_x_q;
    dy_res = dir_y_q;
    miss_l = 1'b0;
    miss_r = 1'b0;
    // A stationary puck must not trigger bounces or points.
    if (puck_speed_in != 4'd0) begin
      if (ny <= 13'sd0) begin
        ny_res = '0;
        dy_res = ~dir_y_q;
      end else if (ny + P_SIZE >= G_HEIGHT) begin
        ny_res = PUCK_Y_MAX;
        dy_res = ~dir_y_q;
      end
      if (!dir_x_q && (nx <= HIT_L_X)) begin
        if (overlap_l) begin
          nx_res = HIT_L_X;
          dx_res = 1'b1;
        end else begin
          miss_l = 1'b1;
        end
      end else if (dir_x_q && (nx >= HIT_R_X)) begin
        if (overlap_r) begin
          nx_res = HIT_R_X;
          dx_res = 1'b0;
        end else begin
          miss_r = 1'b1;
        end
      end
    end
  end

  // ---------------- match state machine ----------------
  logic       serve_eff;
  logic [3:0] score_l_inc, score_r_inc;

  assign serve_eff   = serve_q | serve_in;
  assign score_l_inc = score_l_q + 4'd1;
  assign score_r_inc = score_r_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    puck_x_d  = puck_x_q;
    puck_y_d  = puck_y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    pad_l_d   = pad_l_q;
    pad_r_d   = pad_r_q;
    serve_d   = serve_eff;
    frame_d   = frame_q;
    if (nf_in) begin
      serve_d = 1'b0;
      pad_l_d = pad_l_nx;
      pad_r_d = pad_r_nx;
      unique case (state_q)
        ST_IDLE: begin
          puck_x_d = PUCK_X0;
          puck_y_d = PUCK_Y0;
          if (serve_eff) begin
            state_d = ST_SERVE;
            frame_d = '0;
          end
        end
        ST_SERVE: begin
          puck_x_d = PUCK_X0;
          puck_y_d = PUCK_Y0;
          if (frame_q == FRAME_LAST) begin
            state_d = ST_PLAY;
            frame_d = '0;
          end else begin
            frame_d = frame_q + 16'd1;
          end
        end
        ST_PLAY: begin
          // Wall bounce always updates dir_y; a point then overrides position.
          puck_x_d = nx_res;
          puck_y_d = ny_res;
          dir_x_d  = dx_res;
          dir_y_d  = dy_res;
          if (miss_l) begin
            score_r_d = score_r_inc;
            state_d   = (score_r_inc == WIN) ? ST_GAME_OVER : ST_SERVE;
            puck_x_d  = PUCK_X0;
            puck_y_d  = PUCK_Y0;
            dir_x_d   = 1'b0;
            frame_d   = '0;
          end else if (miss_r) begin
            score_l_d = score_l_inc;
            state_d   = (score_l_inc == WIN) ? ST_GAME_OVER : ST_SERVE;
            puck_x_d  = PUCK_X0;
            puck_y_d  = PUCK_Y0;
            dir_x_d   = 1'b1;
            frame_d   = '0;
          end
        end
        ST_GAME_OVER: begin
          if (serve_eff) begin
            state_d   = ST_IDLE;
            score_l_d = '0;
            score_r_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- rendering ----------------
  logic [23:0] pad_l_rgb, pad_r_rgb, puck_rgb;

  block_sprite #(.WIDTH(PADDLE_WIDTH), .HEIGHT(PADDLE_HEIGHT)) u_spr_pad_l (
    .hcount_i(hcount_in),
    .vcount_i(vcount_in),
    .x_i     (13'd0),
    .y_i     (pad_l_q),
    .color_o (pad_l_rgb)
  );

  block_sprite #(.WIDTH(PADDLE_WIDTH), .HEIGHT(PADDLE_HEIGHT)) u_spr_pad_r (
    .hcount_i(hcount_in),
    .vcount_i(vcount_in),
    .x_i     (PAD_R_X),
    .y_i     (pad_r_q),
    .color_o (pad_r_rgb)
  );

  block_sprite #(.WIDTH(PUCK_SIZE), .HEIGHT(PUCK_SIZE)) u_spr_puck (
    .hcount_i(hcount_in),
    .vcount_i(vcount_in),
    .x_i     (puck_x_q),
    .y_i     (puck_y_q),
    .color_o (puck_rgb)
  );

  always_comb begin
    rgb_d = pad_l_rgb | pad_r_rgb;
    if (state_q == ST_GAME_OVER) begin
      rgb_d = rgb_d | {puck_rgb[23:16], 16'h0};
    end else begin
      rgb_d = rgb_d | puck_rgb;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      score_l_q <= '0;
      score_r_q <= '0;
      puck_x_q  <= PUCK_X0;
      puck_y_q  <= PUCK_Y0;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      pad_l_q   <= PAD_Y0;
      pad_r_q   <= PAD_Y0;
      serve_q   <= 1'b0;
      frame_q   <= '0;
      rgb_q     <= '0;
    end else begin
      state_q   <= state_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      puck_x_q  <= puck_x_d;
      puck_y_q  <= puck_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      pad_l_q   <= pad_l_d;
      pad_r_q   <= pad_r_d;
      serve_q   <= serve_d;
      frame_q   <= frame_d;
      rgb_q     <= rgb_d;
    end
  end

  assign red_out     = rgb_q[23:16];
  assign green_out   = rgb_q[15:8];
  assign blue_out    = rgb_q[7:0];
  assign score_l_out = score_l_q;
  assign score_r_out = score_r_q;
  assign state_out   = state_q;

endmodule

// File: doc/pong_versus.md
# pong_versus

Two-player, parametrised successor of the single-paddle game engine. Holds left and right paddles, a puck, per-player scores and a match state machine, and updates game state once per video frame. Renders sprites for the HDMI pixel pipeline from `hcount_in`/`vcount_in`. Sits between the video timing generator and the TMDS encoder.

## Interface
- `GAME_WIDTH`, 1280: active pixels per line.
- `GAME_HEIGHT`, 720: active lines.
- `PADDLE_WIDTH`, 16: paddle width in pixels.
- `PADDLE_HEIGHT`, 128: paddle height in pixels.
- `PUCK_SIZE`, 32: puck edge length in pixels; the puck is square.
- `WIN_SCORE`, 7: score that ends the match; range 1–15.
- `SERVE_FRAMES`, 60: frames of serve delay.

Ports (clock and reset first):
- `pixel_clk_in` in 1: pixel clock, the only clock.
- `rst_in` in 1: asynchronous, active-high reset.
- `control_in` in 4: [3] right up, [2] right down, [1] left up, [0] left down.
- `serve_in` in 1: level request to serve or restart.
- `puck_speed_in` in 4: puck pixels per frame on each axis.
- `paddle_speed_in` in 4: paddle pixels per frame.
- `nf_in` in 1: one-cycle new-frame strobe.
- `hcount_in` in 11: current pixel column.
- `vcount_in` in 10: current pixel row.
- `red_out`, `green_out`, `blue_out` out 8 each: pixel colour.
- `score_l_out`, `score_r_out` out 4 each: player scores.
- `state_out` out 2: encoded match state.

## Operation
- State changes only in cycles where `nf_in`=1. All other cycles hold every state register.
- `serve_in` is sticky-latched on any cycle and consumed (cleared) on the next `nf_in`.
- States and transitions:
  - IDLE (0): IDLE → SERVE on a latched serve.
  - SERVE (1): frame counter counts `SERVE_FRAMES` frames, then → PLAY.
  - PLAY (2): PLAY → SERVE on a point; PLAY → GAME_OVER when the scoring player reaches `WIN_SCORE`.
  - GAME_OVER (3): GAME_OVER → IDLE on a latched serve; both scores cleared.
- Paddles:
  - Move in IDLE, SERVE and PLAY; frozen in GAME_OVER.
  - Up only: y −= speed. Down only: y += speed. Both or neither: no move.
  - Result clamped to [0, `GAME_HEIGHT`−`PADDLE_HEIGHT`]; no wrap.
  - x positions are fixed: left paddle at 0, right paddle at `GAME_WIDTH`−`PADDLE_WIDTH`.
- Puck in PLAY:
  - Candidate position: nx = x ± speed, ny = y ± speed, computed as 13-bit signed.
  - ny ≤ 0: y=0, flip dir_y.
  - ny+`PUCK_SIZE` ≥ `GAME_HEIGHT`: y=`GAME_HEIGHT`−`PUCK_SIZE`, flip dir_y.
  - Moving left and nx ≤ `PADDLE_WIDTH`:
    - Vertical overlap with the left paddle (puck_y+`PUCK_SIZE` > pad_y and puck_y < pad_y+`PADDLE_HEIGHT`, using pre-update paddle y): x=`PADDLE_WIDTH`, dir_x=1.
    - No overlap: point to the right player.
  - The right edge mirrors this, with threshold `GAME_WIDTH`−`PADDLE_WIDTH`−`PUCK_SIZE`.
- Puck outside PLAY: frozen in GAME_OVER; held centred in IDLE and SERVE.
- On a point: scorer +1, puck recentred, dir_x points toward the player who lost the point, dir_y unchanged, frame counter cleared.
- Rendering:
  - A pixel inside any paddle or the puck gives all three channels 8'hFF; otherwise 0.
  - In GAME_OVER, the puck is drawn red only (8'hFF,0,0).

## Timing
- Pixel outputs are registered: 1-cycle latency from `hcount_in`/`vcount_in`.
- State, score and position registers update on the clock edge at the end of the `nf_in` cycle.
- Scores and `state_out` are direct register outputs.
- Reset values, applied asynchronously and valid mid-frame:
  - State IDLE; scores 0; colour outputs 0.
  - Puck at (`GAME_WIDTH`/2−`PUCK_SIZE`/2, `GAME_HEIGHT`/2−`PUCK_SIZE`/2).
  - Paddles at y=`GAME_HEIGHT`/2−`PADDLE_HEIGHT`/2.
  - dir_x=1, dir_y=1; serve latch and frame counter 0.
- `puck_speed_in`=0: puck stationary, no collision events.
- Scoring and a wall bounce on the same frame: both applied; the point takes precedence for position.

## Configuration
- `PONG_AI_EN` defined: the right paddle tracks the puck.
  - Puck centre more than `PADDLE_HEIGHT`/4 above the paddle centre: move up by `paddle_speed_in`.
  - More than `PADDLE_HEIGHT`/4 below: move down by `paddle_speed_in`.
  - Otherwise: hold.
  - Same clamp rules as player paddles; `control_in[3:2]` ignored.
- Undefined: `control_in[3:2]` drives the right paddle.

## Structure
- `pong_pkg` holds:
  - Match-state enum (IDLE, SERVE, PLAY, GAME_OVER).
  - Default geometry localparams.
  - Signed 13-bit position typedef.
- Sub-module `pong_paddle_ctrl`:
  - Up/down/speed in, clamped y out.
  - Instantiated twice.
  - The AI tracker selects its inputs.
- Sprite drawing reuses `block_sprite`.

## Test plan
- Reset with default parameters:
  - Puck at (624,344); paddles y=296, x=0/1264.
  - `state_out`=0; RGB=0 everywhere; no change across 10 frames without serve.
- Serve, then 60 frames: `state_out` goes 1 → 2. Paddles do not move on cycles without `nf_in`.
- Puck x=20 moving left, speed 4, left paddle y=296, puck y=344 → next frame x=16, dir_x=1, no score change.
- Left paddle y=0, puck y=600 moving left past the edge:
  - `score_r_out` 0 → 1, state SERVE, puck recentred, dir_x=0.
- `score_r_out`=6 plus a miss → 7, GAME_OVER, puck red and frozen. Serve → IDLE, both scores 0.
- Puck y=2 moving up, speed 4 → y=0, dir_y=1.
- Left up held, speed 15, paddle y=10 → y=0 and stays 0. Up and down held together → no move.
